mem_arbiter: RTL

Two-client, single-port memory arbiter between the CPU core and the unified backing memory. It accepts instruction-fetch reads from the fetch port and data reads/writes from the memory-stage port, and serialises them onto one backend command/response interface. It returns each read result to the port that issued it. Data requests have priority, bounded by an anti-starvation counter so fetch always progresses.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/grant_streak.sv | 38 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the CPU/backing-memory arbiter.
// Imported by mem_arbiter and grant_streak.
package mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RD_WAIT
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] wmask;
  } cmd_t;

endpackage

// File: rtl/grant_streak.sv
// Counts back-to-back data grants while a fetch waits and
// forces one fetch grant once the streak limit is reached.
module grant_streak
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_grant,
  input  logic i_grant,
  input  logic i_start,
  output logic force_i
);

  localparam int W = $clog2(MAX_D_STREAK + 2);
  localparam logic [W-1:0] LIMIT = W'(MAX_D_STREAK);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] streak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (i_grant) begin
      streak <= '0;
    end else if (d_grant) begin
      if (!i_start) begin
        streak <= '0;
      end else if (streak != LIMIT) begin
        streak <= streak + ONE;
      end
    end
  end

  assign force_i = (streak == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter serialising fetch and data requests
// onto a single backend memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        i_flush,
  input  logic        d_start,
  input  logic        d_write,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_start,
  output logic        m_write,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [31:0] m_wmask,
  input  logic [31:0] m_rdata,
  input  logic        m_valid
);

  state_t state;
  owner_t owner;
  cmd_t   cmd;
  logic   flush_pending;
  logic   force_i;
  logic   i_acc;
  logic   d_acc;
  logic   m_hs;
  logic   capture;
  logic   i_drop;

  assign d_ready = (state == IDLE) && !force_i;
  assign i_ready = (state == IDLE) && (!d_start || force_i);
  assign i_acc   = i_start && i_ready;
  assign d_acc   = d_start && d_ready;

  assign m_hs    = (state == REQ) && m_ready;
  assign capture = m_valid &&
                   ((m_hs && !cmd.write) || (state == RD_WAIT));
  // a flush in the delivery cycle itself must also drop the fetch
  assign i_drop  = flush_pending || i_flush;

  assign m_write = cmd.write;
  assign m_addr  = cmd.addr;
  assign m_wdata = cmd.wdata;
  assign m_wmask = cmd.wmask;

  grant_streak #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_grant (d_acc),
    .i_grant (i_acc),
    .i_start (i_start),
    .force_i (force_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_I;
      cmd           <= '0;
      flush_pending <= 1'b0;
      m_start       <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      i_valid       <= 1'b0;
      d_valid       <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          flush_pending <= 1'b0;
          if (d_acc) begin
            owner     <= OWN_D;
            cmd.write <= d_write;
            cmd.addr  <= d_addr;
            cmd.wdata <= d_wdata;
            cmd.wmask <= d_wmask;
            m_start   <= 1'b1;
            state     <= REQ;
          end else if (i_acc) begin
            owner     <= OWN_I;
            cmd.write <= 1'b0;
            cmd.addr  <= i_addr;
            cmd.wdata <= '0;
            cmd.wmask <= '0;
            m_start   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ, RD_WAIT: begin
          if (owner == OWN_I && i_flush) begin
            flush_pending <= 1'b1;
          end
          if (m_hs) begin
            m_start <= 1'b0;
          end
          if (capture) begin
            if (owner == OWN_D) begin
              d_rdata <= m_rdata;
              d_valid <= 1'b1;
            end else if (!i_drop) begin
              i_rdata <= m_rdata;
              i_valid <= 1'b1;
            end
            flush_pending <= 1'b0;
            state         <= IDLE;
          end else if (m_hs) begin
            if (cmd.write) begin
              flush_pending <= 1'b0;
              state         <= IDLE;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
